// File: rtl/cam_frame_writer.sv
// Camera byte stream to RGB565 frame buffer writer (line*H_PIX + pixel layout).
// Optional macro CAM_DOWNSCALE_EN: 2:1 decimation of a 2*H_PIX x 2*V_LINES source.
module cam_frame_writer #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done
);

`ifdef CAM_DOWNSCALE_EN
  localparam int SRC_H = 2 * H_PIX;
  localparam int SRC_V = 2 * V_LINES;
`else
  localparam int SRC_H = H_PIX;
  localparam int SRC_V = V_LINES;
`endif
  localparam int PIX_W  = $clog2(SRC_H + 1);
  localparam int LINE_W = $clog2(SRC_V + 1);
  localparam int BASE_W = ADDR_W + 1;

  localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(SRC_H);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(SRC_V);
  localparam logic [BASE_W-1:0] BASE_STEP = BASE_W'(H_PIX);

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    SYNC,
    CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] rst_sync_q;
  logic       rst_n_i;

  logic [PIX_W-1:0]  pix_q;
  logic [LINE_W-1:0] line_q;
  logic [BASE_W-1:0] base_q;
  logic              phase_q;
  logic              href_q;
  logic              wrote_q;
  logic [7:0]        hi_byte_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [15:0]       data_p1;
  logic              done_p1;

  logic              in_capture;
  logic              byte_en;
  logic              pair_en;
  logic              href_fall;
  logic              keep;
  logic              base_inc;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_calc;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_i = rst_sync_q[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_VSYNC: if (vsync)  state_d = SYNC;
      SYNC:       if (!vsync) state_d = CAPTURE;
      CAPTURE:    if (vsync)  state_d = SYNC;
      default:                state_d = WAIT_VSYNC;
    endcase
  end

  always_comb begin
    in_capture = (state_q == CAPTURE) && !vsync;
    byte_en    = in_capture && href;
    pair_en    = byte_en && phase_q;
    href_fall  = in_capture && href_q && !href;
`ifdef CAM_DOWNSCALE_EN
    // Only even source pixels on even source lines survive; the base advances
    // once per pair of source lines.
    keep      = (pix_q < PIX_MAX) && (line_q < LINE_MAX) && !pix_q[0] && !line_q[0];
    addr_calc = base_q[ADDR_W-1:0] + ADDR_W'(pix_q >> 1);
    base_inc  = line_q[0] && (line_q < LINE_MAX);
`else
    keep      = (pix_q < PIX_MAX) && (line_q < LINE_MAX);
    addr_calc = base_q[ADDR_W-1:0] + ADDR_W'(pix_q);
    base_inc  = (line_q < LINE_MAX);
`endif
    wr_en = pair_en && keep;
  end

  // Stage p0: byte assembly and position counters; stage p1: write port register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= WAIT_VSYNC;
      pix_q      <= '0;
      line_q     <= '0;
      base_q     <= '0;
      phase_q    <= 1'b0;
      href_q     <= 1'b0;
      wrote_q    <= 1'b0;
      hi_byte_p0 <= '0;
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      done_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      href_q  <= href;
      vld_p1  <= wr_en;
      done_p1 <= (state_q == CAPTURE) && vsync && wrote_q;
      if (wr_en) begin
        addr_p1 <= addr_calc;
        data_p1 <= {hi_byte_p0, cam_data};
      end
      if (state_q == SYNC) begin
        pix_q   <= '0;
        line_q  <= '0;
        base_q  <= '0;
        phase_q <= 1'b0;
        wrote_q <= 1'b0;
      end else if (byte_en) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hi_byte_p0 <= cam_data;
        end else if (pix_q < PIX_MAX) begin
          pix_q <= pix_q + PIX_W'(1);
        end
        if (wr_en) begin
          wrote_q <= 1'b1;
        end
      end else if (href_fall) begin
        // An odd trailing byte is dropped by clearing the phase here.
        pix_q   <= '0;
        phase_q <= 1'b0;
        if (pix_q != '0) begin
          if (line_q < LINE_MAX) begin
            line_q <= line_q + LINE_W'(1);
          end
          if (base_inc) begin
            base_q <= base_q + BASE_STEP;
          end
        end
      end
    end
  end

  assign we         = vld_p1;
  assign wAddr      = addr_p1;
  assign wData      = data_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer: a frame-level model predicts every write and frame_done.
module tb_cam_frame_writer;
  localparam int H_PIX   = 320;
  localparam int V_LINES = 6;
  localparam int ADDR_W  = 11;
`ifdef CAM_DOWNSCALE_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int SRC_H = S * H_PIX;
  localparam int SRC_V = S * V_LINES;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              vsync = 1'b0;
  logic              href = 1'b0;
  logic [7:0]        cam_data = '0;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [15:0]       wData;
  logic              frame_done;

  cam_frame_writer #(
    .H_PIX  (H_PIX),
    .V_LINES(V_LINES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .href      (href),
    .cam_data  (cam_data),
    .we        (we),
    .wAddr     (wAddr),
    .wData     (wData),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fails = 0;
  int  n_wr = 0;
  int  first_addr = -1;
  int  last_addr = -1;
  int  got_done = 0;
  int  exp_done = 0;
  bit  armed = 1'b0;
  bit  frame_wrote = 1'b0;
  int  m_line = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Reference: destination position derived directly from source line/pixel.
  function automatic void model_pixel(int p, logic [15:0] d);
    int  a;
    wr_t e;
    a = -1;
    if (!armed) return;
    if (S == 1) begin
      if (p < H_PIX && m_line < V_LINES) a = m_line * H_PIX + p;
    end else if (p < SRC_H && m_line < SRC_V && p % 2 == 0 && m_line % 2 == 0) begin
      a = (m_line / 2) * H_PIX + p / 2;
    end
    if (a >= 0) begin
      e.a = ADDR_W'(a);
      e.d = d;
      exp_q.push_back(e);
      frame_wrote = 1'b1;
    end
  endfunction

  function automatic void model_rise();
    vsync = 1'b1;
    if (armed && frame_wrote) exp_done++;
    frame_wrote = 1'b0;
    m_line = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs", {we, frame_done, wData, 3'b000, wAddr}, 32'h0);
    end else begin
      if (we === 1'b1) begin
        if (n_wr == 0) first_addr = int'(wAddr);
        last_addr = int'(wAddr);
        n_wr++;
        check("addr_bound", 32'(wAddr > ADDR_W'(H_PIX * V_LINES - 1)), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", wAddr, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", wAddr, mon_e.a);
          check("write_data", wData, mon_e.d);
        end
      end
      if (frame_done === 1'b1) got_done++;
    end
  end

  task automatic send_line(int nbytes, int pat, bit abort, bit keep_href, int mark_pix);
    logic [7:0]  b;
    logic [7:0]  hi;
    logic [15:0] pv;
    hi = '0;
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      pv = (pat >= 0) ? pat[15:0] : 16'($urandom);
      if (i / 2 == mark_pix) pv = 16'h1234;
      b = (i % 2 == 0) ? pv[15:8] : pv[7:0];
      cam_data = b;
      if (i % 2 == 0) hi = b;
      else if (abort && i == nbytes - 1) model_rise();
      else model_pixel(i / 2, {hi, b});
      tick();
      if (i % 2 == 1 && i / 2 == mark_pix && armed) begin
        check("latency_we", we, 1);
        check("latency_addr", wAddr, m_line * H_PIX + mark_pix);
        check("latency_data", wData, 16'h1234);
      end
    end
    if (abort) begin
      href = 1'b0;
      return;
    end
    if (keep_href) return;
    href = 1'b0;
    if (nbytes / 2 > 0) m_line++;
    repeat (3) tick();
  endtask

  task automatic vsync_pulse();
    href = 1'b0;
    if (!vsync) model_rise();
    repeat (4) tick();
    vsync = 1'b0;
    armed = 1'b1;
    repeat (3) tick();
  endtask

  task automatic frame_check(string name, int exp_wr);
    check({name, "_frame_done"}, got_done, exp_done);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    if (exp_wr >= 0) check({name, "_writes"}, n_wr, exp_wr);
    n_wr = 0;
  endtask

  initial begin
    int nl;
    int len;
    #2 reset_n = 1'b0;
    href = 1'b1;
    repeat (4) begin
      cam_data = 8'($urandom);
      tick();
    end
    reset_n = 1'b1;
    send_line(10, -1, 0, 0, -1);
    send_line(10, -1, 0, 0, -1);
    check("unarmed_no_write", n_wr, 0);
    vsync_pulse();
    frame_check("first_sync", 0);

    for (int l = 0; l < SRC_V; l++) send_line(2 * SRC_H, 16'hF800, 0, 0, -1);
    vsync_pulse();
    check("full_first_addr", first_addr, 0);
    check("full_last_addr", last_addr, H_PIX * V_LINES - 1);
    frame_check("full_frame", H_PIX * V_LINES);

    for (int l = 0; l < SRC_V + 2; l++) send_line(2 * SRC_H + 3, -1, 0, 0, -1);
    vsync_pulse();
    frame_check("clip_frame", H_PIX * V_LINES);

    for (int l = 0; l < 6; l++) send_line(16, -1, 0, 0, (S == 1 && l == 5) ? 7 : -1);
    vsync_pulse();
    frame_check("short_frame", -1);

    for (int f = 0; f < 2; f++) begin
      nl = $urandom_range(1, SRC_V + 1);
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * SRC_H + 4) : $urandom_range(0, 24);
        send_line(len, -1, 0, 0, -1);
      end
      send_line(2 * $urandom_range(1, 12), -1, 1, 0, -1);
      vsync_pulse();
      frame_check("random_abort_frame", -1);
    end

    send_line(1, -1, 0, 0, -1);
    vsync_pulse();
    frame_check("empty_frame", 0);

    for (int l = 0; l < 3; l++) send_line(20, -1, 0, 0, -1);
    send_line(9, -1, 0, 1, -1);
    reset_n = 1'b0;
    #1;
    check("async_reset_we", we, 0);
    check("async_reset_addr", wAddr, 0);
    check("async_reset_data", wData, 0);
    check("async_reset_done", frame_done, 0);
    check("reset_queue_empty", exp_q.size(), 0);
    armed = 1'b0;
    frame_wrote = 1'b0;
    m_line = 0;
    n_wr = 0;
    repeat (3) begin
      cam_data = 8'($urandom);
      tick();
    end
    reset_n = 1'b1;
    send_line(12, -1, 0, 0, -1);
    check("post_reset_no_write", n_wr, 0);
    vsync_pulse();
    frame_check("post_reset_sync", 0);
    send_line(16, -1, 0, 0, -1);
    send_line(16, -1, 0, 0, -1);
    vsync_pulse();
    check("post_reset_first_addr", first_addr, 0);
    frame_check("post_reset_frame", (S == 1) ? 16 : 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
